// File: rtl/trace_pkg.sv
// Shared definitions for the 32016 debug trace stream: line layout, frame sizes
// and the frame decoder used by the receiver.
package trace_pkg;

    localparam int STROBE_BIT = 7;
    localparam int LAST_BIT   = 6;
    localparam int GROUP_W    = 6;
    localparam int PC_GROUPS  = 5;
    localparam int WR_GROUPS  = 11;
    localparam int SR_W       = WR_GROUPS * GROUP_W;
    localparam int GRP_CNT_W  = 4;

    localparam logic [1:0] WR_MARKER = 2'b10;

    typedef enum logic {
        REC_PC = 1'b0,
        REC_WR = 1'b1
    } rec_type_t;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_IDLE,
        ST_RECV
    } rx_state_t;

    typedef struct packed {
        logic        ok;
        rec_type_t   rtype;
        logic [23:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } rec_t;

    // sr is right-aligned: the last group received sits in bits [5:0].
    function automatic rec_t frame_decode(input logic [SR_W-1:0]      sr,
                                          input logic [GRP_CNT_W-1:0] groups);
        rec_t r;
        r = '0;
        if (groups == GRP_CNT_W'(PC_GROUPS)) begin
            r.ok    = (sr[5:0] == 6'd0);
            r.rtype = REC_PC;
            r.addr  = sr[29:6];
        end else if (groups == GRP_CNT_W'(WR_GROUPS)) begin
            r.ok    = (sr[65:62] == 4'd0) && (sr[5:4] == WR_MARKER);
            r.rtype = REC_WR;
            r.addr  = sr[61:38];
            r.data  = sr[37:6];
            r.be    = sr[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_stream_rx_if.sv
// Decoded trace record channel: valid/ready handshake plus record payload.
interface trace_stream_rx_if;

    logic        rec_valid;
    logic        rec_ready;
    logic        rec_type;
    logic [23:0] rec_addr;
    logic [31:0] rec_data;
    logic [3:0]  rec_be;

    modport master (
        output rec_valid,
        output rec_type,
        output rec_addr,
        output rec_data,
        output rec_be,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_type,
        input  rec_addr,
        input  rec_data,
        input  rec_be,
        output rec_ready
    );

endinterface

// File: rtl/trace_sync_edge.sv
// Synchronises the asynchronous trace port into fastclk and flags rising strobe
// edges; group data and last flag are taken from the same synchronised word.
module trace_sync_edge
    import trace_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               fastclk,
    input  logic               rst_b,
    input  logic [7:0]         trace_in,
    output logic [GROUP_W-1:0] grp_data,
    output logic               grp_last,
    output logic               edge_det
);

    // Chain resets to a high strobe so a line already idling high is not an edge.
    localparam logic [7:0] IDLE_LINE = 8'(1 << STROBE_BIT);

    logic [SYNC_STAGES-1:0][7:0] chain_reg;
    logic                        strobe_prev_reg;
    logic [7:0]                  s;

    assign s = chain_reg[SYNC_STAGES-1];

    always_ff @(posedge fastclk or negedge rst_b) begin
        if (!rst_b) begin
            chain_reg       <= {SYNC_STAGES{IDLE_LINE}};
            strobe_prev_reg <= 1'b1;
        end else begin
            chain_reg       <= {chain_reg[SYNC_STAGES-2:0], trace_in};
            strobe_prev_reg <= s[STROBE_BIT];
        end
    end

    assign edge_det = s[STROBE_BIT] & ~strobe_prev_reg;
    assign grp_data = s[GROUP_W-1:0];
    assign grp_last = s[LAST_BIT];

endmodule

// File: rtl/trace_stream_rx.sv
// Trace stream receiver: frames 6-bit groups, decodes PC / IO-write records and
// presents them on a valid/ready channel with error and statistics outputs.
module trace_stream_rx
    import trace_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16
) (
    input  logic              fastclk,
    input  logic              rst_b,
    input  logic [7:0]        trace_in,
    trace_stream_rx_if.master rec,
    output logic              frame_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  pc_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int                    TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]       TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [GRP_CNT_W-1:0]  GRP_OVF = GRP_CNT_W'(WR_GROUPS + 1);

    logic [GROUP_W-1:0] grp_data;
    logic               grp_last;
    logic               edge_det;

    trace_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .fastclk (fastclk),
        .rst_b   (rst_b),
        .trace_in(trace_in),
        .grp_data(grp_data),
        .grp_last(grp_last),
        .edge_det(edge_det)
    );

    rx_state_t            state_reg, state_next;
    logic [GRP_CNT_W-1:0] grp_reg, grp_next;
    logic [SR_W-1:0]      sr_reg, sr_next;
    logic [TO_W-1:0]      idle_cnt_reg, idle_cnt_next;

    logic [SR_W-1:0]      sr_shift;
    logic [GRP_CNT_W-1:0] grp_inc;
    rec_t                 dec;
    logic                 timeout_hit;
    logic                 err_evt;
    logic                 good_evt;

    assign sr_shift    = {sr_reg[SR_W-GROUP_W-1:0], grp_data};
    assign grp_inc     = grp_reg + GRP_CNT_W'(1);
    assign dec         = frame_decode(sr_shift, grp_inc);
    assign timeout_hit = (idle_cnt_reg == TO_LAST);

    always_comb begin
        state_next    = state_reg;
        grp_next      = grp_reg;
        sr_next       = sr_reg;
        idle_cnt_next = idle_cnt_reg;
        err_evt       = 1'b0;
        good_evt      = 1'b0;
        unique case (state_reg)
            // Resynchronising: wait for a frame end or a quiet line.
            ST_HUNT: begin
                if (edge_det) begin
                    idle_cnt_next = '0;
                    if (grp_last) begin
                        state_next = ST_IDLE;
                        grp_next   = '0;
                    end
                end else if (timeout_hit) begin
                    state_next    = ST_IDLE;
                    grp_next      = '0;
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt_reg + TO_W'(1);
                end
            end
            ST_IDLE: begin
                idle_cnt_next = '0;
                if (edge_det) begin
                    sr_next = {{(SR_W-GROUP_W){1'b0}}, grp_data};
                    if (grp_last) begin
                        err_evt  = 1'b1;
                        grp_next = '0;
                    end else begin
                        state_next = ST_RECV;
                        grp_next   = GRP_CNT_W'(1);
                    end
                end
            end
            ST_RECV: begin
                if (edge_det) begin
                    idle_cnt_next = '0;
                    sr_next       = sr_shift;
                    grp_next      = grp_inc;
                    if (grp_last) begin
                        state_next = ST_IDLE;
                        grp_next   = '0;
                        good_evt   = dec.ok;
                        err_evt    = ~dec.ok;
                    end else if (grp_inc == GRP_OVF) begin
                        err_evt    = 1'b1;
                        state_next = ST_HUNT;
                        grp_next   = '0;
                    end
                end else if (timeout_hit) begin
                    err_evt       = 1'b1;
                    state_next    = ST_IDLE;
                    grp_next      = '0;
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt_reg + TO_W'(1);
                end
            end
            default: state_next = ST_HUNT;
        endcase
    end

    always_ff @(posedge fastclk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg    <= ST_HUNT;
            grp_reg      <= '0;
            sr_reg       <= '0;
            idle_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grp_reg      <= grp_next;
            sr_reg       <= sr_next;
            idle_cnt_reg <= idle_cnt_next;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A good decode with the held record still unaccepted is dropped as an overrun.
    always_ff @(posedge fastclk or negedge rst_b) begin
        if (!rst_b) begin
            rec.rec_valid <= 1'b0;
            rec.rec_type  <= 1'b0;
            rec.rec_addr  <= '0;
            rec.rec_data  <= '0;
            rec.rec_be    <= '0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
            pc_cnt        <= '0;
            wr_cnt        <= '0;
            err_cnt       <= '0;
        end else begin
            frame_err <= err_evt;
            overrun   <= 1'b0;
            if (err_evt) begin
                err_cnt <= sat_inc(err_cnt);
            end
            if (good_evt && rec.rec_valid && !rec.rec_ready) begin
                overrun <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
            end else if (good_evt) begin
                rec.rec_valid <= 1'b1;
                rec.rec_type  <= dec.rtype;
                rec.rec_addr  <= dec.addr;
                rec.rec_data  <= dec.data;
                rec.rec_be    <= dec.be;
                if (dec.rtype == REC_WR) begin
                    wr_cnt <= sat_inc(wr_cnt);
                end else begin
                    pc_cnt <= sat_inc(pc_cnt);
                end
            end else if (rec.rec_valid && rec.rec_ready) begin
                rec.rec_valid <= 1'b0;
            end
        end
    end

endmodule
